// File: rtl/encoder4a2_pkg.sv
// ---------------------------------------------------------------------------
// encoder4a2_pkg
// Shared types and sizes for the encoder4a2 request encoder.
//   state_t : handshake FSM states (IDLE waits for a pending event,
//             PRESENT holds a code until the consumer acknowledges it)
//   N_REQ   : number of request lines
//   CODE_W  : width of the presented code
// ---------------------------------------------------------------------------
package encoder4a2_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   localparam int N_REQ  = 4;
   localparam int CODE_W = 2;

endpackage : encoder4a2_pkg

// File: rtl/encoder4a2_prio.sv
// ---------------------------------------------------------------------------
// prio_pick4
// Combinational priority picker over four pending flags. The search visits
// every line once, beginning at 'start' and stepping up (DESCEND=0) or down
// (DESCEND=1) modulo 4. The first pending line visited wins.
//   pend  [3:0] in  : pending flags, bit i for line i
//   start [1:0] in  : first line visited by the search
//   code  [1:0] out : index of the winning line (0 when nothing is pending)
//   any         out : at least one line is pending
// Parameter DESCEND selects the search direction.
// ---------------------------------------------------------------------------
module prio_pick4
   import encoder4a2_pkg::*;
#(
   parameter bit DESCEND = 1'b0
) (
   input  logic [N_REQ-1:0]  pend,
   input  logic [CODE_W-1:0] start,
   output logic [CODE_W-1:0] code,
   output logic              any
);

   // The loop runs from the farthest offset down to offset 0, so the line
   // closest to 'start' is the last one written and therefore wins.
   always_comb begin
      logic [CODE_W-1:0] w_idx;
      // NOTE: every output gets a default before the loop so no path leaves
      // it unassigned, which would otherwise infer a latch.
      code  = '0;
      any   = 1'b0;
      w_idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_idx = DESCEND ? (start - CODE_W'(k)) : (start + CODE_W'(k));
         if (pend[w_idx]) begin
            code = w_idx;
            any  = 1'b1;
         end
      end
   end

endmodule : prio_pick4

// File: rtl/encoder4a2.sv
// ---------------------------------------------------------------------------
// encoder4a2
// Sequential 4-to-2 request encoder. It latches each rising edge on d0..d3
// as a pending event. It presents one pending event at a time as the code
// {s1,s0} under a valid/ack handshake.
//   clk        in  : sole clock, rising edge
//   rst_n      in  : asynchronous active-low reset
//   d0..d3     in  : request lines, synchronous to clk; line i -> code i
//   ack        in  : consumer accepts the presented code (level, sampled)
//   s1, s0     out : presented code, held while valid=0 (consumer ignores)
//   valid      out : {s1,s0} carries a granted code
//   pend [3:0] out : pending-event flags, bit i for line i
// Configuration macro ENC_ROUND_ROBIN_EN:
//   defined   -> rotating priority that starts after the last grant
//   undefined -> fixed priority, d3 highest; no last-grant register
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module encoder4a2
   import encoder4a2_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             d0,
   input  logic             d1,
   input  logic             d2,
   input  logic             d3,
   input  logic             ack,
   output logic             s1,
   output logic             s0,
   output logic             valid,
   output logic [N_REQ-1:0] pend
);

   logic [N_REQ-1:0]  r_d_q;
   logic [N_REQ-1:0]  r_pend;
   logic [CODE_W-1:0] r_code;
   logic              r_valid;
   state_t            r_state;

   logic [N_REQ-1:0]  w_d;
   logic [N_REQ-1:0]  w_event;
   logic [N_REQ-1:0]  w_clr;
   logic [CODE_W-1:0] w_code;
   logic              w_any;

   assign w_d     = {d3, d2, d1, d0};
   assign w_event = w_d & ~r_d_q;
   // Clear the presented line only on the accepting edge.
   assign w_clr   = (r_state == PRESENT && ack) ? (N_REQ'(1) << r_code) : '0;

`ifdef ENC_ROUND_ROBIN_EN
   logic [CODE_W-1:0] r_last;
   logic [CODE_W-1:0] w_start;

   // Reset value 3 makes the first search begin at line 0.
   assign w_start = r_last + CODE_W'(1);

   prio_pick4 #(.DESCEND(1'b0)) u_pick (
      .pend  (r_pend),
      .start (w_start),
      .code  (w_code),
      .any   (w_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= CODE_W'(3);
      end else if (r_state == IDLE && w_any) begin
         r_last <= w_code;
      end
   end
`else
   // A descending search from line 3 is a fixed highest-index-first priority.
   prio_pick4 #(.DESCEND(1'b1)) u_pick (
      .pend  (r_pend),
      .start (CODE_W'(3)),
      .code  (w_code),
      .any   (w_any)
   );
`endif

   // Edge capture and pending flags. The set term comes after the clear, so a
   // new event wins over the acknowledge on the same line in the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d_q  <= '0;
         r_pend <= '0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every
         // register samples the pre-edge values, whatever the statement order.
         r_d_q  <= w_d;
         r_pend <= (r_pend & ~w_clr) | w_event;
      end
   end

   // Handshake FSM with registered code and valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_code  <= '0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_code  <= w_code;
                  r_valid <= 1'b1;
                  r_state <= PRESENT;
               end
            end
            PRESENT: begin
               if (ack) begin
                  r_valid <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign s1    = r_code[1];
   assign s0    = r_code[0];
   assign valid = r_valid;
   assign pend  = r_pend;

endmodule : encoder4a2

// File: tb/tb_encoder4a2.sv
// ---------------------------------------------------------------------------
// tb_encoder4a2
// Self-checking bench for encoder4a2. It compares the DUT against a
// behavioural model that applies the block's rules: edge detection, the
// pending set, grant selection and the handshake. The bench follows
// ENC_ROUND_ROBIN_EN the same way the design does.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_encoder4a2;

   logic       clk;
   logic       rst_n;
   logic [3:0] d_in;
   logic       ack;
   logic       s1, s0, valid;
   logic [3:0] pend;

   int n_checks = 0;
   int n_err    = 0;

   encoder4a2 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .d0    (d_in[0]),
      .d1    (d_in[1]),
      .d2    (d_in[2]),
      .d3    (d_in[3]),
      .ack   (ack),
      .s1    (s1),
      .s0    (s0),
      .valid (valid),
      .pend  (pend)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   bit m_prev [4];
   bit m_pend [4];
   bit m_valid;
   int m_code;
   int m_last;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_prev[i] = 1'b0;
         m_pend[i] = 1'b0;
      end
      m_valid = 1'b0;
      m_code  = 0;
      m_last  = 3;
   endtask

   function automatic int model_pick();
      int w = -1;
`ifdef ENC_ROUND_ROBIN_EN
      for (int k = 1; k <= 4; k++)
         if (w < 0 && m_pend[(m_last + k) % 4]) w = (m_last + k) % 4;
`else
      for (int i = 3; i >= 0; i--)
         if (w < 0 && m_pend[i]) w = i;
`endif
      return w;
   endfunction

   task automatic model_edge();
      bit ev [4];
      int clr = -1;
      int w;
      for (int i = 0; i < 4; i++) ev[i] = d_in[i] && !m_prev[i];
      if (m_valid) begin
         if (ack) begin
            clr     = m_code;
            m_valid = 1'b0;
         end
      end else begin
         w = model_pick();
         if (w >= 0) begin
            m_code  = w;
            m_valid = 1'b1;
            m_last  = w;
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (i == clr) m_pend[i] = 1'b0;
         if (ev[i])    m_pend[i] = 1'b1;
         m_prev[i] = d_in[i];
      end
   endtask

   function automatic logic [3:0] model_pend_vec();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = m_pend[i];
      return v;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".valid"}, {3'b0, valid}, {3'b0, m_valid});
      check({tag, ".code"},  {2'b0, s1, s0}, 4'(m_code));
      check({tag, ".pend"},  pend, model_pend_vec());
   endtask

   // One clock: the model steps on the rising edge with the same inputs the
   // DUT samples, and outputs are compared on the falling edge.
   task automatic tick(input string tag);
      @(posedge clk);
      if (rst_n) model_edge();
      else       model_reset();
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      tick("rst");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [1:0] got_q [$];
   int         n_rise;
   logic       prev_valid;

   initial begin
      rst_n = 1'b0;
      d_in  = 4'b0000;
      ack   = 1'b0;
      model_reset();
      #2;
      check("reset.valid", {3'b0, valid}, 4'h0);
      check("reset.code",  {2'b0, s1, s0}, 4'h0);
      check("reset.pend",  pend, 4'h0);
      tick("reset_hold");
      @(negedge clk);
      rst_n = 1'b1;

      // Single pulse on d2 with ack high: valid two edges after sampling.
      ack  = 1'b1;
      d_in = 4'b0100;
      tick("d2_k");
      check("d2_pend_k", pend, 4'b0100);
      check("d2_valid_k", {3'b0, valid}, 4'h0);
      d_in = 4'b0000;
      tick("d2_k1");
      check("d2_valid_k1", {3'b0, valid}, 4'h1);
      check("d2_code", {2'b0, s1, s0}, 4'h2);
      tick("d2_ack");
      check("d2_done_valid", {3'b0, valid}, 4'h0);
      check("d2_done_pend", pend, 4'h0);

      // d0, d1, d3 together from a fresh reset.
      do_reset();
      ack  = 1'b1;
      d_in = 4'b1011;
      tick("three_set");
      d_in = 4'b0000;
      got_q.delete();
      for (int c = 0; c < 7; c++) begin
         tick("three_run");
         if (valid) got_q.push_back({s1, s0});
      end
      check("three_count", 4'(got_q.size()), 4'd3);
      if (got_q.size() == 3) begin
`ifdef ENC_ROUND_ROBIN_EN
         check("three_0", {2'b0, got_q[0]}, 4'h0);
         check("three_1", {2'b0, got_q[1]}, 4'h1);
         check("three_2", {2'b0, got_q[2]}, 4'h3);
`else
         check("three_0", {2'b0, got_q[0]}, 4'h3);
         check("three_1", {2'b0, got_q[1]}, 4'h1);
         check("three_2", {2'b0, got_q[2]}, 4'h0);
`endif
      end

      // Re-pulse d0 and d3 together.
      d_in = 4'b1001;
      tick("two_set");
      d_in = 4'b0000;
      got_q.delete();
      for (int c = 0; c < 5; c++) begin
         tick("two_run");
         if (valid) got_q.push_back({s1, s0});
      end
      check("two_count", 4'(got_q.size()), 4'd2);
      if (got_q.size() == 2) begin
`ifdef ENC_ROUND_ROBIN_EN
         check("two_0", {2'b0, got_q[0]}, 4'h0);
         check("two_1", {2'b0, got_q[1]}, 4'h3);
`else
         check("two_0", {2'b0, got_q[0]}, 4'h3);
         check("two_1", {2'b0, got_q[1]}, 4'h0);
`endif
      end

      // d1 held high for 10 cycles; ack low for 5 cycles after valid.
      ack    = 1'b0;
      d_in   = 4'b0010;
      n_rise = 0;
      prev_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         ack = (c >= 7);
         tick("hold_run");
         if (valid && !prev_valid) n_rise++;
         prev_valid = valid;
         if (c >= 1 && c <= 6) check("hold_code", {2'b0, s1, s0}, 4'h1);
      end
      check("hold_single", 4'(n_rise), 4'd1);
      d_in = 4'b0000;
      tick("hold_idle");

      // New d1 edge on the same edge as the ack of a presented 01.
      ack  = 1'b0;
      d_in = 4'b0010;
      tick("race_set");
      d_in = 4'b0000;
      tick("race_grant");
      check("race_code", {2'b0, s1, s0}, 4'h1);
      d_in = 4'b0010;
      ack  = 1'b1;
      tick("race_ack");
      check("race_pend_kept", pend, 4'b0010);
      check("race_valid_low", {3'b0, valid}, 4'h0);
      d_in = 4'b0000;
      tick("race_again");
      check("race_valid_again", {3'b0, valid}, 4'h1);
      check("race_code_again", {2'b0, s1, s0}, 4'h1);
      tick("race_drain");

      // Async reset while presenting with pend=1010.
      do_reset();
      ack  = 1'b0;
      d_in = 4'b1010;
      tick("ar_set");
      d_in = 4'b0000;
      tick("ar_grant");
      check("ar_pend_before", pend, 4'b1010);
      check("ar_valid_before", {3'b0, valid}, 4'h1);
      #2;
      rst_n = 1'b0;
      d_in  = 4'b1000;
      #1;
      model_reset();
      check("ar_valid_now", {3'b0, valid}, 4'h0);
      check("ar_code_now",  {2'b0, s1, s0}, 4'h0);
      check("ar_pend_now",  pend, 4'h0);
      tick("ar_hold");
      @(negedge clk);
      rst_n = 1'b1;
      ack   = 1'b1;
      n_rise = 0;
      prev_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick("ar_after");
         if (valid && !prev_valid) begin
            n_rise++;
            check("ar_code_after", {2'b0, s1, s0}, 4'h3);
         end
         prev_valid = valid;
      end
      check("ar_single", 4'(n_rise), 4'd1);

      // Randomized traffic, checked against the model every cycle.
      for (int c = 0; c < 400; c++) begin
         d_in = 4'($urandom_range(0, 15));
         ack  = ($urandom_range(0, 3) != 0);
         tick("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_encoder4a2

// File: doc/encoder4a2.md
# encoder4a2

Sequential 4-to-2 request encoder: the opposite end of the team's `decoder1de4`, which turns a 2-bit code `{s1,s0}` into one of four lines. This block watches four request lines and latches each rising edge as a pending event. It presents one pending event at a time as a 2-bit code with a valid/ack handshake. It sits between four event sources (buttons, sensor strobes, or another block's one-hot outputs) and a consumer that can accept one code at a time.

## Interface
- Parameters: none. Width is fixed at 4 request lines and a 2-bit code.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; one clock domain.
- `d0`,`d1`,`d2`,`d3`  in  1 each  request lines, synchronous to `clk`; line index i maps to code i.
- `ack`  in  1  consumer accepts the presented code.
- `s1`,`s0`  out  1 each  presented code, `{s1,s0}` = index of the granted line.
- `valid`  out  1  code on `{s1,s0}` is valid.
- `pend`  out  4  pending-event flags, bit i for line i.

## Operation
- Edge capture: `d_q[i]` registers `d[i]` every cycle. An event on line i is `d[i] & ~d_q[i]`.
- An event sets `pend[i]`. A second event on a line already pending merges into that flag; it is not counted twice.
- FSM states, enum `IDLE`, `PRESENT`:
  - `IDLE`: if `pend != 0`, pick a winner (see Configuration), load its index into `{s1,s0}`, set `valid=1`, go to `PRESENT`. Otherwise stay. `ack` is ignored in `IDLE`.
  - `PRESENT`: `{s1,s0}` and `valid` are held stable. When `ack=1`, clear `pend[{s1,s0}]`, set `valid=0`, return to `IDLE`.
- Simultaneous clear and new event on the same line, same edge: the set wins, so the new event stays pending.
- Events on other lines during `PRESENT` are latched normally and are not lost.
- `{s1,s0}` keeps its last value while `valid=0`. The consumer must ignore it.
- Reset values: `s1=0`, `s0=0`, `valid=0`, `pend=4'b0000`, `d_q=4'b0000`, state `IDLE`, last-grant register `2'd3`.
- Reset mid-operation clears everything immediately and drops all pending events. Because `d_q` resets to 0, a line held high across reset release produces an event at the first clock edge after release.

## Timing
- Rising `d[i]` first sampled at edge k: `pend[i]=1` after edge k.
- With the FSM in `IDLE`, `valid=1` after edge k+1. Minimum latency is 2 edges.
- `ack` sampled high at edge m: after edge m, `valid=0` and `pend` bit cleared.
- Earliest next `valid=1` is after edge m+1. Maximum throughput is one code per 2 cycles.
- `ack` must be a level sampled on the edge. Holding `ack` high permanently yields one code every 2 cycles.
- `valid` is never asserted in the same cycle as the event that caused it. There is no combinational path from any `d` or `ack` input to any output.

## Configuration
- `ENC_ROUND_ROBIN_EN`:
  - Defined: rotating priority. The search starts at `(last_grant+1) mod 4` and ascends with wrap-around; the first pending line wins. `last_grant` updates on each grant. Its reset value `3` means the first search starts at line 0.
  - Undefined: fixed priority, highest index wins (`d3` > `d2` > `d1` > `d0`). The last-grant register is not built.

## Structure
- Package `encoder4a2_pkg`:
  - `typedef enum {IDLE, PRESENT} state_t`
  - `localparam N_REQ = 4`
  - `localparam CODE_W = 2`
- Sub-module `prio_pick4` (combinational): inputs `pend[3:0]`, `start[1:0]`; outputs `code[1:0]` and `any`. In fixed mode it is instantiated with a descending search; it is the only place where priority logic lives.

## Test plan
- Reset, then pulse `d2` for 1 cycle, `ack` tied high → `valid=1` 2 edges after `d2` is sampled, `{s1,s0}=10`, then `valid=0` and `pend=0000`.
- `d0`,`d1`,`d3` rise on the same edge, `ack` high, fixed mode → codes 11, 01, 00 in that order, each `valid` pulse 1 cycle with a 1-cycle gap.
- Same stimulus with `ENC_ROUND_ROBIN_EN` → codes 00, 01, 11. Then re-pulse `d0` and `d3` together → 00 granted before 11 (search starts at 0 after last grant 3).
- `d1` held high 10 cycles, `ack=0` for 5 cycles after `valid` → single event, `{s1,s0}=01` stable throughout, exactly one code delivered.
- In `PRESENT` with code 01, new `d1` rising edge on the same edge as `ack=1` → `pend[1]` stays 1 and a second 01 code follows 1 cycle later.
- `rst_n` asserted while `valid=1` with `pend=1010` → outputs go to reset values immediately without a clock. After release with `d3` held high → one event, code 11.
